sq_sweep_ctrl: RTL and testbench

Sequencer for the square-wave generator. It sweeps the generator's frequency input from a start value to a stop value in fixed increments and holds each frequency for a programmed dwell time. Retuning happens only on a `square_in` toggle, so the generator's timer never overruns a shortened period. The block sits between the configuration registers and the generator, and drives the generator's `Freq` input and reset.

---
 rtl/sq_sweep_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sq_sweep_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_sweep_ctrl.sv
// Frequency sweep sequencer for the square-wave generator; retunes only on a square_in toggle.
// Latency: start -> freq_out/freq_upd two cycles later; square_in toggle -> retune two cycles later.
// Backpressure: none; abort (level) stops the sweep at once. SQ_SWEEP_PINGPONG_EN makes the sweep bounce until abort.
module sq_sweep_ctrl #(
    parameter int          FREQ_W  = 32,
    parameter int          DWELL_W = 24,
    parameter int unsigned F_MIN   = 1,
    parameter int unsigned F_MAX   = 12_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               square_in,
    output logic [FREQ_W-1:0]  freq_out,
    output logic               gen_rst_n,
    output logic               freq_upd,
    output logic               busy,
    output logic               done,
    output logic [15:0]        step_idx
);

    localparam logic [FREQ_W-1:0] FMIN_W = FREQ_W'(F_MIN);
    localparam logic [FREQ_W-1:0] FMAX_W = FREQ_W'(F_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DWELL,
        S_WAIT_EDGE,
        S_STEP,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [FREQ_W-1:0]  cfg_start, cfg_stop, cfg_step;
    logic [DWELL_W-1:0] cfg_dwell, dwell_cnt, dwell_ld;
    logic               dir_up;
    logic               sq_q;
    logic               sq_edge;
    logic               at_end;

    logic latch_cfg, do_load, do_step, do_swap, done_nxt;

    logic [FREQ_W-1:0] start_clamped, stop_clamped;
    logic [FREQ_W:0]   sum_ext, dif_ext;
    logic [FREQ_W-1:0] freq_next;

    function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] f);
        if (f < FMIN_W)
            return FMIN_W;
        else if (f > FMAX_W)
            return FMAX_W;
        else
            return f;
    endfunction

    assign start_clamped = clamp_freq(f_start);
    assign stop_clamped  = clamp_freq(f_stop);
    assign dwell_ld      = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
    assign sq_edge       = square_in ^ sq_q;
    assign at_end        = (freq_out == cfg_stop) || (cfg_step == '0);
    assign busy          = (state != S_IDLE);

    // Extra top bit carries the overflow (up) or borrow (down) so the stop clamp catches wraps.
    always_comb begin
        sum_ext   = {1'b0, freq_out} + {1'b0, cfg_step};
        dif_ext   = {1'b0, freq_out} - {1'b0, cfg_step};
        freq_next = cfg_stop;
        if (dir_up) begin
            if (!sum_ext[FREQ_W] && (sum_ext[FREQ_W-1:0] <= cfg_stop))
                freq_next = sum_ext[FREQ_W-1:0];
        end else begin
            if (!dif_ext[FREQ_W] && (dif_ext[FREQ_W-1:0] >= cfg_stop))
                freq_next = dif_ext[FREQ_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_cfg = 1'b0;
        do_load   = 1'b0;
        do_step   = 1'b0;
        do_swap   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                do_load   = 1'b1;
                state_nxt = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_cnt <= DWELL_W'(1))
                    state_nxt = S_WAIT_EDGE;
            end
            S_WAIT_EDGE: begin
                if (sq_edge) begin
                    if (at_end) begin
`ifdef SQ_SWEEP_PINGPONG_EN
                        do_swap   = 1'b1;
                        state_nxt = S_STEP;
`else
                        state_nxt = S_FINISH;
`endif
                    end else begin
                        state_nxt = S_STEP;
                    end
                end
            end
            S_STEP: begin
                do_step   = 1'b1;
                state_nxt = S_DWELL;
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides every transition and suppresses all register actions.
        if (abort) begin
            state_nxt = S_IDLE;
            latch_cfg = 1'b0;
            do_load   = 1'b0;
            do_step   = 1'b0;
            do_swap   = 1'b0;
        end
        done_nxt = (state_nxt == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_start <= FMIN_W;
            cfg_stop  <= FMIN_W;
            cfg_step  <= '0;
            cfg_dwell <= '0;
            dir_up    <= 1'b1;
            dwell_cnt <= '0;
            sq_q      <= 1'b0;
            freq_out  <= FMIN_W;
            gen_rst_n <= 1'b0;
            freq_upd  <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
        end else begin
            sq_q     <= square_in;
            freq_upd <= 1'b0;
            done     <= done_nxt;

            if (latch_cfg) begin
                cfg_start <= start_clamped;
                cfg_stop  <= stop_clamped;
                cfg_step  <= f_step;
                cfg_dwell <= dwell;
                dir_up    <= (stop_clamped >= start_clamped);
            end

            if (do_swap) begin
                cfg_start <= cfg_stop;
                cfg_stop  <= cfg_start;
                dir_up    <= ~dir_up;
            end

            if (do_load) begin
                freq_out  <= cfg_start;
                freq_upd  <= 1'b1;
                gen_rst_n <= 1'b1;
                dwell_cnt <= dwell_ld;
                step_idx  <= '0;
            end else if (do_step) begin
                freq_out  <= freq_next;
                freq_upd  <= 1'b1;
                dwell_cnt <= dwell_ld;
                if (step_idx != 16'hFFFF)
                    step_idx <= step_idx + 16'd1;
            end else if (state == S_DWELL && !abort) begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end

            if (abort || state == S_FINISH)
                gen_rst_n <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sq_sweep_ctrl.sv
// Directed bench for sq_sweep_ctrl with a behavioural square generator and a frequency scoreboard.
module tb_sq_sweep_ctrl;

    localparam int GEN_DIV = 20000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [31:0] f_start, f_stop, f_step;
    logic [23:0] dwell;
    logic        square_in;
    logic [31:0] freq_out;
    logic        gen_rst_n, freq_upd, busy, done;
    logic [15:0] step_idx;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] f;
        logic [15:0] idx;
    } exp_t;
    exp_t exp_q[$];

    sq_sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .square_in (square_in),
        .freq_out  (freq_out),
        .gen_rst_n (gen_rst_n),
        .freq_upd  (freq_upd),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx)
    );

    always #5 clk = ~clk;

    // Generator model: toggles every half = GEN_DIV/Freq cycles, held in reset by gen_rst_n.
    int   timer = 0;
    int   prev_timer = 0;
    logic sq = 1'b0;
    bit   overrun = 0;
    bit   zero_seen = 0;
    assign square_in = sq;

    function automatic int half_of(input logic [31:0] f);
        int h;
        h = (f == 0) ? 1 : GEN_DIV / int'(f);
        return (h < 1) ? 1 : h;
    endfunction

    always @(posedge clk) begin
        if (!gen_rst_n) begin
            timer <= 0;
            sq    <= 1'b0;
        end else if (timer >= half_of(freq_out) - 1) begin
            timer <= 0;
            sq    <= ~sq;
        end else begin
            timer <= timer + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] f, input logic [15:0] idx);
        exp_t e;
        e.f = f;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every freq_upd must match the next queued frequency/step index.
    always @(negedge clk) begin
        if (rst_n && freq_upd) begin
            chk("upd_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("freq_out", 64'(freq_out), 64'(e.f));
                chk("step_idx", 64'(step_idx), 64'(e.idx));
                chk("timer_at_retune", 64'(prev_timer <= 1), 64'd1);
            end
        end
        if (done === 1'b1)
            done_cnt++;
        if (gen_rst_n && freq_out == 0)
            zero_seen = 1;
        if (gen_rst_n && timer >= half_of(freq_out))
            overrun = 1;
        prev_timer = timer;
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic kick(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                        input logic [23:0] dw);
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit seen);
        seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic wait_q_empty(input int max, output bit seen);
        seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                seen = 1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int d0;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        f_start = '0;
        f_stop  = '0;
        f_step  = '0;
        dwell   = '0;
        cycles(3);
        chk("rst_freq_out", 64'(freq_out), 64'd1);
        chk("rst_gen_rst_n", 64'(gen_rst_n), 64'd0);
        chk("rst_freq_upd", 64'(freq_upd), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_step_idx", 64'(step_idx), 64'd0);
        rst_n = 1'b1;
        cycles(2);

`ifdef SQ_SWEEP_PINGPONG_EN
        push(100, 0); push(200, 1); push(300, 2);
        push(200, 3); push(100, 4); push(200, 5);
        kick(100, 300, 100, 2);
        wait_q_empty(20000, seen);
        chk("pp_sequence_seen", 64'(seen), 64'd1);
        chk("pp_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("pp_abort_busy", 64'(busy), 64'd0);
        chk("pp_abort_gen_rst", 64'(gen_rst_n), 64'd0);
        cycles(3);
        chk("pp_no_done", 64'(done_cnt), 64'd0);
`else
        // Up sweep, with a start pulse mid-sweep that must be ignored.
        push(1000, 0); push(2000, 1); push(3000, 2); push(4000, 3);
        d0 = done_cnt;
        kick(1000, 4000, 1000, 10);
        chk("up_busy_n1", 64'(busy), 64'd1);
        chk("up_upd_n1", 64'(freq_upd), 64'd0);
        @(negedge clk);
        chk("up_upd_n2", 64'(freq_upd), 64'd1);
        chk("up_gen_rst_n2", 64'(gen_rst_n), 64'd1);
        cycles(4);
        kick(7, 8, 1, 1);
        wait_done(5000, seen);
        chk("up_done_seen", 64'(seen), 64'd1);
        chk("up_busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        chk("up_busy_after", 64'(busy), 64'd0);
        chk("up_gen_rst_after", 64'(gen_rst_n), 64'd0);
        cycles(3);
        chk("up_done_once", 64'(done_cnt - d0), 64'd1);
        chk("up_q_drained", 64'(exp_q.size()), 64'd0);

        // Down sweep with overshoot clamp; config changes after start must not matter.
        push(5000, 0); push(3000, 1); push(1000, 2); push(100, 3);
        kick(5000, 100, 2000, 3);
        f_stop = 9999;
        f_step = 1;
        wait_done(5000, seen);
        chk("down_done_seen", 64'(seen), 64'd1);
        chk("down_last_freq", 64'(freq_out), 64'd100);
        cycles(2);
        chk("down_q_drained", 64'(exp_q.size()), 64'd0);

        // Range clamp, zero step and zero dwell: single F_MIN frequency.
        push(1, 0);
        d0 = done_cnt;
        kick(0, 20_000_000, 0, 0);
        wait_done(30000, seen);
        chk("clamp_done_seen", 64'(seen), 64'd1);
        chk("clamp_freq", 64'(freq_out), 64'd1);
        cycles(2);
        chk("clamp_done_once", 64'(done_cnt - d0), 64'd1);

        // Abort during DWELL at step 2, then restart from step 0.
        push(1000, 0); push(2000, 1); push(3000, 2);
        kick(1000, 4000, 1000, 50);
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (freq_upd && step_idx == 16'd2) begin
                seen = 1;
                break;
            end
        end
        chk("abort_reached_step2", 64'(seen), 64'd1);
        cycles(3);
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_gen_rst", 64'(gen_rst_n), 64'd0);
        chk("abort_freq_held", 64'(freq_out), 64'd3000);
        cycles(3);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        push(1000, 0); push(2000, 1); push(3000, 2); push(4000, 3);
        kick(1000, 4000, 1000, 5);
        wait_done(5000, seen);
        chk("restart_done_seen", 64'(seen), 64'd1);
        cycles(2);
        chk("restart_q_drained", 64'(exp_q.size()), 64'd0);
`endif

        chk("no_zero_freq", 64'(zero_seen), 64'd0);
        chk("no_timer_overrun", 64'(overrun), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
